// File: rtl/jtag_ahb_dap.sv
// jtag_ahb_dap: JTAG debug access port that drives a single-beat AHB master.
// The TAP, the data registers and the bus master all run on TCK.
// Ports:
//   TCK, TRST_N        clock, asynchronous active-low reset
//   TMS, TDI, TDO      JTAG serial interface (TDO changes on falling TCK)
//   TDO_EN             TDO drive enable, high while shifting IR or DR
//   HADDR/HWRITE/HTRANS/HSIZE/HWDATA  AHB master request outputs
//   HRDATA/HREADY/HRESP               AHB master response inputs
//
// TAP state       | meaning
// TLR             | test-logic-reset, IR forced to IDCODE
// RTI             | run-test/idle
// SEL_DR/SEL_IR   | select DR / IR column
// CAP_*           | parallel load of the selected shift register
// SHIFT_*         | serial shift, TDO enabled
// EXIT1/PAUSE/EXIT2 | shift suspension states
// UPD_DR/UPD_IR   | update from the shift register
//
// Bus state       | meaning
// B_IDLE          | no transfer, HTRANS = IDLE
// B_APHASE        | address phase, HTRANS = NONSEQ
// B_DPHASE        | data phase, waiting for HREADY
module jtag_ahb_dap #(
  parameter int          IR_W       = 4,
  parameter int          ADDR_W     = 32,
  parameter int          DATA_W     = 32,
  parameter logic [31:0] IDCODE_VAL = 32'hF0F0F0F1,
  parameter bit          AUTOINC    = 1'b1
) (
  input  logic              TCK,
  input  logic              TRST_N,
  input  logic              TMS,
  input  logic              TDI,
  output logic              TDO,
  output logic              TDO_EN,
  output logic [ADDR_W-1:0] HADDR,
  output logic              HWRITE,
  output logic [1:0]        HTRANS,
  output logic [2:0]        HSIZE,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  localparam int MAXAD = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int DRW   = (MAXAD > 32) ? MAXAD : 32;

  localparam logic [IR_W-1:0] OP_IDCODE = IR_W'(1);
  localparam logic [IR_W-1:0] OP_ADDR   = IR_W'(2);
  localparam logic [IR_W-1:0] OP_WDATA  = IR_W'(3);
  localparam logic [IR_W-1:0] OP_RDATA  = IR_W'(4);
  localparam logic [IR_W-1:0] OP_STATUS = IR_W'(5);

  localparam logic [2:0]        SIZE = (DATA_W == 8) ? 3'd0 : (DATA_W == 16) ? 3'd1 : 3'd2;
  localparam logic [ADDR_W-1:0] INC  = ADDR_W'(DATA_W / 8);

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
    SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
  } tap_t;

  typedef enum logic [1:0] {B_IDLE, B_APHASE, B_DPHASE} bus_t;

  tap_t tap_state, tap_next;
  bus_t bus_state, bus_next;

  logic [IR_W-1:0]   ir_sr, ir_q;
  logic [DRW-1:0]    dr_sr, dr_cap, dr_shift;
  int                dr_len;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rbuf_q;
  logic              err_q, ovr_q;
  logic              busy, upd_dr, acc_req, issue, drop, done;

  // TAP controller
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) tap_state <= TLR;
    else         tap_state <= tap_next;
  end

  always_comb begin
    tap_next = tap_state;
    case (tap_state)
      TLR:      tap_next = TMS ? TLR      : RTI;
      RTI:      tap_next = TMS ? SEL_DR   : RTI;
      SEL_DR:   tap_next = TMS ? SEL_IR   : CAP_DR;
      CAP_DR:   tap_next = TMS ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: tap_next = TMS ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: tap_next = TMS ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: tap_next = TMS ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: tap_next = TMS ? UPD_DR   : SHIFT_DR;
      UPD_DR:   tap_next = TMS ? SEL_DR   : RTI;
      SEL_IR:   tap_next = TMS ? TLR      : CAP_IR;
      CAP_IR:   tap_next = TMS ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: tap_next = TMS ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: tap_next = TMS ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: tap_next = TMS ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: tap_next = TMS ? UPD_IR   : SHIFT_IR;
      UPD_IR:   tap_next = TMS ? SEL_DR   : RTI;
      default:  tap_next = TLR;
    endcase
  end

  // Selected DR: length and capture value; unassigned opcodes fall to BYPASS
  always_comb begin
    dr_len = 1;
    dr_cap = '0;
    case (ir_q)
      OP_IDCODE: begin dr_len = 32;     dr_cap = DRW'(IDCODE_VAL); end
      OP_ADDR:   begin dr_len = ADDR_W; dr_cap = DRW'(addr_q); end
      OP_WDATA:  begin dr_len = DATA_W; dr_cap = DRW'(wdata_q); end
      OP_RDATA:  begin dr_len = DATA_W; dr_cap = DRW'(rbuf_q); end
      OP_STATUS: begin dr_len = 3;      dr_cap = DRW'({ovr_q, err_q, busy}); end
      default:   begin dr_len = 1;      dr_cap = '0; end
    endcase
  end

  // One physical shift register serves every DR; TDI enters at the MSB of
  // the currently selected length so bit0 is always the next TDO bit.
  always_comb begin
    dr_shift = dr_sr >> 1;
    for (int i = 0; i < DRW; i++)
      if (i == dr_len - 1) dr_shift[i] = TDI;
  end

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      ir_sr <= '0;
      dr_sr <= '0;
    end else begin
      if (tap_state == CAP_IR)        ir_sr <= IR_W'(1);
      else if (tap_state == SHIFT_IR) ir_sr <= {TDI, ir_sr[IR_W-1:1]};
      if (tap_state == CAP_DR)        dr_sr <= dr_cap;
      else if (tap_state == SHIFT_DR) dr_sr <= dr_shift;
    end
  end

  // Falling-edge side: IR update and TDO/TDO_EN
  always_ff @(negedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      ir_q   <= OP_IDCODE;
      TDO    <= 1'b0;
      TDO_EN <= 1'b0;
    end else begin
      if (tap_state == TLR)         ir_q <= OP_IDCODE;
      else if (tap_state == UPD_IR) ir_q <= ir_sr;
      TDO_EN <= (tap_state == SHIFT_IR) || (tap_state == SHIFT_DR);
      if (tap_state == SHIFT_IR)      TDO <= ir_sr[0];
      else if (tap_state == SHIFT_DR) TDO <= dr_sr[0];
      else                            TDO <= 1'b0;
    end
  end

  // AHB master
  assign upd_dr  = (tap_state == UPD_DR);
  assign busy    = (bus_state != B_IDLE);
  assign acc_req = upd_dr && ((ir_q == OP_WDATA) || (ir_q == OP_RDATA));
  assign issue   = acc_req && !busy;
  assign drop    = acc_req && busy;
  assign done    = (bus_state == B_DPHASE) && HREADY;

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) bus_state <= B_IDLE;
    else         bus_state <= bus_next;
  end

  always_comb begin
    bus_next = bus_state;
    HTRANS   = 2'b00;
    case (bus_state)
      B_IDLE:   if (issue) bus_next = B_APHASE;
      B_APHASE: begin
        HTRANS = 2'b10;
        if (HREADY) bus_next = B_DPHASE;
      end
      B_DPHASE: if (HREADY) bus_next = B_IDLE;
      default:  bus_next = B_IDLE;
    endcase
  end

  assign HSIZE  = SIZE;
  assign HWDATA = wdata_q;

  // Statement order sets priority: a status clear loses to a same-edge
  // error, and an ADDR update overrides a same-edge increment.
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      HADDR   <= '0;
      HWRITE  <= 1'b0;
      wdata_q <= '0;
      addr_q  <= '0;
      rbuf_q  <= '0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (issue) begin
        HADDR  <= addr_q;
        HWRITE <= (ir_q == OP_WDATA);
        if (ir_q == OP_WDATA) wdata_q <= dr_sr[DATA_W-1:0];
      end
      if (upd_dr && (ir_q == OP_STATUS)) begin
        if (dr_sr[2]) ovr_q <= 1'b0;
        if (dr_sr[1]) err_q <= 1'b0;
      end
      if (done) begin
        if (HRESP) err_q <= 1'b1;
        else begin
          if (!HWRITE) rbuf_q <= HRDATA;
          if (AUTOINC) addr_q <= addr_q + INC;
        end
      end
      if (upd_dr && (ir_q == OP_ADDR)) addr_q <= dr_sr[ADDR_W-1:0];
      if (drop) ovr_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jtag_ahb_dap.sv
// Testbench for jtag_ahb_dap: drives JTAG scans, models an AHB slave through
// HREADY/HRESP/HRDATA, and checks bus transfers against a scoreboard queue.
module tb_jtag_ahb_dap;

  logic        TCK = 1'b0;
  logic        TRST_N = 1'b0;
  logic        TMS = 1'b1;
  logic        TDI = 1'b0;
  logic        TDO, TDO_EN, HWRITE;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [31:0] HRDATA = 32'h0;
  logic        HREADY = 1'b1;
  logic        HRESP = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
  } xfer_t;

  xfer_t       sb_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] dout;
  logic [3:0]  ir_cap;
  bit          en_all;
  xfer_t       cur;
  bit          pend = 1'b0;

  jtag_ahb_dap dut (
    .TCK(TCK), .TRST_N(TRST_N), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TDO_EN(TDO_EN),
    .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #10 TCK = ~TCK;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Bus monitor: sampled mid-low-phase, after the bench has set HREADY for
  // the coming rising edge.
  always @(negedge TCK) begin
    #5;
    if (!TRST_N) pend = 1'b0;
    else begin
      if (pend && HREADY) begin
        pend = 1'b0;
        if (cur.wr) begin
          checks++;
          if (HWDATA !== cur.data) begin
            errors++;
            $display("FAIL bus_hwdata: got %h expected %h", HWDATA, cur.data);
          end
        end
      end
      if (HTRANS == 2'b10 && HREADY) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL bus_unexpected: transfer at %h, none expected", HADDR);
        end else begin
          cur = sb_q.pop_front();
          if (HADDR !== cur.addr || HWRITE !== cur.wr) begin
            errors++;
            $display("FAIL bus_addr: got %h/%b expected %h/%b", HADDR, HWRITE, cur.addr, cur.wr);
          end
          pend = 1'b1;
        end
      end
    end
  end

  task automatic tap_step(input logic tms, input logic tdi, output logic tdo);
    @(negedge TCK); #1;
    tdo = TDO;
    TMS = tms;
    TDI = tdi;
    @(posedge TCK); #1;
  endtask

  task automatic go(input logic tms);
    logic d;
    tap_step(tms, 1'b0, d);
  endtask

  task automatic tap_reset;
    repeat (5) go(1'b1);
    go(1'b0);
  endtask

  task automatic shift_ir(input logic [3:0] code);
    logic b;
    go(1'b1); go(1'b1); go(1'b0); go(1'b0);
    for (int i = 0; i < 4; i++) begin
      tap_step(i == 3, code[i], b);
      ir_cap[i] = b;
    end
    go(1'b1); go(1'b0);
  endtask

  task automatic shift_dr(input int n, input logic [31:0] din, input bit rel);
    logic b;
    dout = '0;
    en_all = 1'b1;
    go(1'b1); go(1'b0); go(1'b0);
    for (int i = 0; i < n; i++) begin
      tap_step(i == n - 1, din[i], b);
      dout[i] = b;
      en_all = en_all & TDO_EN;
    end
    if (rel) HREADY = 1'b1;
    go(1'b1); go(1'b0);
  endtask

  task automatic test_reset;
    #5;
    checks += 6;
    if (HTRANS !== 2'b00) begin errors++; $display("FAIL rst_htrans: got %b expected 00", HTRANS); end
    if (HWRITE !== 1'b0)  begin errors++; $display("FAIL rst_hwrite: got %b expected 0", HWRITE); end
    if (HADDR !== 32'h0)  begin errors++; $display("FAIL rst_haddr: got %h expected 0", HADDR); end
    if (HWDATA !== 32'h0) begin errors++; $display("FAIL rst_hwdata: got %h expected 0", HWDATA); end
    if (TDO !== 1'b0 || TDO_EN !== 1'b0) begin
      errors++; $display("FAIL rst_tdo: got %b/%b expected 0/0", TDO, TDO_EN);
    end
    if (HSIZE !== 3'b010) begin errors++; $display("FAIL hsize: got %b expected 010", HSIZE); end
    @(negedge TCK); #1;
    TRST_N = 1'b1;
    go(1'b0);
  endtask

  task automatic test_idcode;
    shift_dr(32, 32'h0, 1'b0);
    checks += 3;
    if (dout !== 32'hF0F0F0F1) begin errors++; $display("FAIL idcode: got %h expected f0f0f0f1", dout); end
    if (en_all !== 1'b1) begin errors++; $display("FAIL tdo_en_shift: got %b expected 1", en_all); end
    if (TDO_EN !== 1'b0) begin errors++; $display("FAIL tdo_en_idle: got %b expected 0", TDO_EN); end
  endtask

  task automatic test_write;
    HREADY = 1'b1;
    shift_ir(4'd2);
    checks++;
    if (ir_cap !== 4'b0001) begin errors++; $display("FAIL ir_capture: got %b expected 0001", ir_cap); end
    shift_dr(32, 32'h100, 1'b0);
    shift_ir(4'd3);
    sb_q.push_back('{addr: 32'h100, wr: 1'b1, data: 32'hDEADBEEF});
    shift_dr(32, 32'hDEADBEEF, 1'b0);
    shift_ir(4'd2);
    shift_dr(32, 32'h104, 1'b0);
    checks++;
    if (dout !== 32'h104) begin errors++; $display("FAIL write_autoinc: got %h expected 104", dout); end
  endtask

  task automatic test_read;
    shift_ir(4'd2);
    shift_dr(32, 32'h200, 1'b0);
    shift_ir(4'd4);
    HRDATA = 32'hBAD0BAD0;
    sb_q.push_back('{addr: 32'h200, wr: 1'b0, data: 32'h0});
    rd_q.push_back(32'h12345678);
    shift_dr(32, 32'h0, 1'b0);
    checks += 3;
    if (dout !== 32'h0) begin errors++; $display("FAIL rbuf_initial: got %h expected 0", dout); end
    if (HTRANS !== 2'b10) begin errors++; $display("FAIL htrans_aphase: got %b expected 10", HTRANS); end
    go(1'b0);
    if (HTRANS !== 2'b00) begin errors++; $display("FAIL htrans_one_cycle: got %b expected 00", HTRANS); end
    HREADY = 1'b0;
    go(1'b0); go(1'b0);
    HREADY = 1'b1;
    HRDATA = 32'h12345678;
    go(1'b0);
    HRDATA = 32'hBAD0BAD0;
    sb_q.push_back('{addr: 32'h204, wr: 1'b0, data: 32'h0});
    shift_dr(32, 32'h0, 1'b0);
    checks++;
    if (rd_q.size() == 0) begin errors++; $display("FAIL rdata_queue: empty, expected one entry"); end
    else begin
      cur = '{addr: 32'h0, wr: 1'b0, data: rd_q.pop_front()};
      if (dout !== cur.data) begin errors++; $display("FAIL rdata: got %h expected %h", dout, cur.data); end
    end
  endtask

  task automatic test_error;
    shift_ir(4'd2);
    shift_dr(32, 32'h300, 1'b0);
    HRESP = 1'b1;
    shift_ir(4'd3);
    sb_q.push_back('{addr: 32'h300, wr: 1'b1, data: 32'hA5A5A5A5});
    shift_dr(32, 32'hA5A5A5A5, 1'b0);
    shift_ir(4'd5);
    HRESP = 1'b0;
    shift_dr(3, 32'h2, 1'b0);
    checks += 3;
    if (dout !== 32'h2) begin errors++; $display("FAIL status_err: got %b expected 010", dout[2:0]); end
    shift_dr(3, 32'h0, 1'b0);
    if (dout !== 32'h0) begin errors++; $display("FAIL status_err_clear: got %b expected 000", dout[2:0]); end
    shift_ir(4'd2);
    shift_dr(32, 32'h300, 1'b0);
    if (dout !== 32'h300) begin errors++; $display("FAIL err_no_inc: got %h expected 300", dout); end
  endtask

  task automatic test_overrun;
    shift_ir(4'd2);
    shift_dr(32, 32'h400, 1'b0);
    HREADY = 1'b0;
    shift_ir(4'd3);
    sb_q.push_back('{addr: 32'h400, wr: 1'b1, data: 32'h11111111});
    shift_dr(32, 32'h11111111, 1'b0);
    shift_dr(32, 32'h22222222, 1'b0);
    checks += 5;
    if (dout !== 32'h11111111) begin errors++; $display("FAIL wdata_capture: got %h expected 11111111", dout); end
    shift_ir(4'd5);
    shift_dr(3, 32'h0, 1'b0);
    if (dout !== 32'h5) begin errors++; $display("FAIL status_overrun: got %b expected 101", dout[2:0]); end
    tap_reset;
    if (HTRANS !== 2'b10) begin errors++; $display("FAIL tlr_no_abort: got %b expected 10", HTRANS); end
    HREADY = 1'b1;
    shift_ir(4'd5);
    shift_dr(3, 32'h4, 1'b0);
    if (dout !== 32'h4) begin errors++; $display("FAIL status_sticky: got %b expected 100", dout[2:0]); end
    shift_dr(3, 32'h0, 1'b0);
    if (dout !== 32'h0) begin errors++; $display("FAIL status_ovr_clear: got %b expected 000", dout[2:0]); end
  endtask

  task automatic test_addr_wins;
    shift_ir(4'd2);
    shift_dr(32, 32'h600, 1'b0);
    shift_ir(4'd3);
    HREADY = 1'b0;
    sb_q.push_back('{addr: 32'h600, wr: 1'b1, data: 32'h33333333});
    shift_dr(32, 32'h33333333, 1'b0);
    shift_ir(4'd2);
    shift_dr(32, 32'h700, 1'b1);
    checks += 2;
    if (dout !== 32'h600) begin errors++; $display("FAIL addr_busy_capture: got %h expected 600", dout); end
    shift_dr(32, 32'h700, 1'b0);
    if (dout !== 32'h700) begin errors++; $display("FAIL addr_update_wins: got %h expected 700", dout); end
  endtask

  task automatic test_wrap;
    shift_ir(4'd2);
    shift_dr(32, 32'hFFFFFFFC, 1'b0);
    shift_ir(4'd3);
    sb_q.push_back('{addr: 32'hFFFFFFFC, wr: 1'b1, data: 32'h44444444});
    shift_dr(32, 32'h44444444, 1'b0);
    shift_ir(4'd2);
    shift_dr(32, 32'h0, 1'b0);
    checks++;
    if (dout !== 32'h0) begin errors++; $display("FAIL addr_wrap: got %h expected 0", dout); end
  endtask

  task automatic test_trst_mid;
    shift_ir(4'd2);
    shift_dr(32, 32'h800, 1'b0);
    shift_ir(4'd3);
    sb_q.push_back('{addr: 32'h800, wr: 1'b1, data: 32'h55555555});
    shift_dr(32, 32'h55555555, 1'b0);
    go(1'b0);
    HREADY = 1'b0;
    go(1'b1); go(1'b0); go(1'b0); go(1'b0);
    checks += 7;
    if (TDO_EN !== 1'b1 || HWRITE !== 1'b1) begin
      errors++; $display("FAIL pre_trst: got en=%b hwrite=%b expected 1/1", TDO_EN, HWRITE);
    end
    #4;
    TRST_N = 1'b0;
    #1;
    if (HTRANS !== 2'b00) begin errors++; $display("FAIL trst_htrans: got %b expected 00", HTRANS); end
    if (TDO_EN !== 1'b0) begin errors++; $display("FAIL trst_tdo_en: got %b expected 0", TDO_EN); end
    if (HWRITE !== 1'b0) begin errors++; $display("FAIL trst_hwrite: got %b expected 0", HWRITE); end
    if (HADDR !== 32'h0) begin errors++; $display("FAIL trst_haddr: got %h expected 0", HADDR); end
    if (HWDATA !== 32'h0) begin errors++; $display("FAIL trst_hwdata: got %h expected 0", HWDATA); end
    @(negedge TCK); #7;
    TRST_N = 1'b1;
    HREADY = 1'b1;
    go(1'b0);
    shift_dr(32, 32'h0, 1'b0);
    if (dout !== 32'hF0F0F0F1) begin errors++; $display("FAIL idcode_after_trst: got %h expected f0f0f0f1", dout); end
  endtask

  initial begin
    test_reset;
    test_idcode;
    test_write;
    test_read;
    test_error;
    test_overrun;
    test_addr_wins;
    test_wrap;
    test_trst_mid;
    repeat (4) go(1'b0);
    checks++;
    if (sb_q.size() != 0 || rd_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d/%0d entries expected 0/0", sb_q.size(), rd_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
